// File: rtl/hazard_stall_unit.sv
`default_nettype none
// ============================================================================
// Module   : hazard_stall_unit
// Brief    : Load-use / branch-operand RAW hazard detector with a stall FSM.
//            HAZARD_PERF_CNT_EN enables saturating stall/flush counters.
// Revision : 1.0 - initial release
// ============================================================================
module hazard_stall_unit #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [4:0]       ID_Rs,
    input  logic [4:0]       ID_Rt,
    input  logic             ID_usesRs,
    input  logic             ID_usesRt,
    input  logic             ID_isBranch,
    input  logic             ID_branchTaken,
    input  logic             ID_Ex_MemRead,
    input  logic             ID_Ex_Regwrite,
    input  logic [4:0]       ID_Ex_WriteReg,
    input  logic             EX_MemMemRead,
    input  logic [4:0]       EX_MemWriteReg,
    input  logic             mem_stall,
    output logic             pc_write,
    output logic             IF_ID_write,
    output logic             ID_Ex_bubble,
    output logic             IF_ID_flush,
    output logic             stall_active,
    output logic [CNT_W-1:0] stall_cycles,
    output logic [CNT_W-1:0] flush_count
);

    typedef enum logic [0:0] {
        IDLE       = 1'b0,
        STALL_LAST = 1'b1
    } state_t;

    state_t     r_state;
    logic       w_ex_match;
    logic       w_mem_match;
    logic [1:0] w_need;
    logic       w_hazard_stall;
    logic       w_flush;

    // x0 is hardwired zero, so it can never carry a dependency.
    function automatic logic src_match(input logic uses, input logic [4:0] src,
                                       input logic [4:0] dst);
        return uses && (dst != 5'd0) && (src == dst);
    endfunction

    assign w_ex_match  = src_match(ID_usesRs, ID_Rs, ID_Ex_WriteReg) ||
                         src_match(ID_usesRt, ID_Rt, ID_Ex_WriteReg);
    assign w_mem_match = src_match(ID_usesRs, ID_Rs, EX_MemWriteReg) ||
                         src_match(ID_usesRt, ID_Rt, EX_MemWriteReg);

    always_comb begin
        w_need = 2'd0;
        if (r_state == IDLE) begin
            if (ID_isBranch && ID_Ex_MemRead && w_ex_match)
                w_need = 2'd2;
            else if ((!ID_isBranch && ID_Ex_MemRead && w_ex_match) ||
                     (ID_isBranch && ID_Ex_Regwrite && !ID_Ex_MemRead && w_ex_match) ||
                     (ID_isBranch && EX_MemMemRead && w_mem_match))
                w_need = 2'd1;
        end
    end

    assign w_hazard_stall = (r_state == STALL_LAST) || (w_need != 2'd0);
    // A taken resolution while stalled used stale operands; it re-resolves later.
    assign w_flush        = ID_branchTaken && !w_hazard_stall && !mem_stall;

    assign pc_write     = !mem_stall && !w_hazard_stall;
    assign IF_ID_write  = !mem_stall && !w_hazard_stall;
    assign ID_Ex_bubble = !mem_stall && w_hazard_stall;
    assign IF_ID_flush  = w_flush;
    assign stall_active = w_hazard_stall;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= IDLE;
        end else if (!mem_stall) begin
            case (r_state)
                IDLE:       r_state <= (w_need == 2'd2) ? STALL_LAST : IDLE;
                STALL_LAST: r_state <= IDLE;
                default:    r_state <= IDLE;
            endcase
        end
    end

`ifdef HAZARD_PERF_CNT_EN
    logic [CNT_W-1:0] r_stall_cycles;
    logic [CNT_W-1:0] r_flush_count;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_stall_cycles <= '0;
            r_flush_count  <= '0;
        end else begin
            if (w_hazard_stall && !mem_stall && (r_stall_cycles != '1))
                r_stall_cycles <= r_stall_cycles + CNT_W'(1);
            if (w_flush && (r_flush_count != '1))
                r_flush_count <= r_flush_count + CNT_W'(1);
        end
    end

    assign stall_cycles = r_stall_cycles;
    assign flush_count  = r_flush_count;
`else
    assign stall_cycles = '0;
    assign flush_count  = '0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_hazard_stall_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_hazard_stall_unit
// Brief    : Directed vector table plus multi-cycle sequences for hazard_stall_unit.
// Revision : 1.0 - initial release
// ============================================================================
module tb_hazard_stall_unit;

    localparam int CNT_W = 4;

    logic             clk = 1'b0;
    logic             reset;
    logic [4:0]       ID_Rs, ID_Rt, ID_Ex_WriteReg, EX_MemWriteReg;
    logic             ID_usesRs, ID_usesRt, ID_isBranch, ID_branchTaken;
    logic             ID_Ex_MemRead, ID_Ex_Regwrite, EX_MemMemRead, mem_stall;
    logic             pc_write, IF_ID_write, ID_Ex_bubble, IF_ID_flush, stall_active;
    logic [CNT_W-1:0] stall_cycles, flush_count;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    hazard_stall_unit #(.CNT_W(CNT_W)) dut (
        .clk(clk), .reset(reset),
        .ID_Rs(ID_Rs), .ID_Rt(ID_Rt), .ID_usesRs(ID_usesRs), .ID_usesRt(ID_usesRt),
        .ID_isBranch(ID_isBranch), .ID_branchTaken(ID_branchTaken),
        .ID_Ex_MemRead(ID_Ex_MemRead), .ID_Ex_Regwrite(ID_Ex_Regwrite),
        .ID_Ex_WriteReg(ID_Ex_WriteReg), .EX_MemMemRead(EX_MemMemRead),
        .EX_MemWriteReg(EX_MemWriteReg), .mem_stall(mem_stall),
        .pc_write(pc_write), .IF_ID_write(IF_ID_write), .ID_Ex_bubble(ID_Ex_bubble),
        .IF_ID_flush(IF_ID_flush), .stall_active(stall_active),
        .stall_cycles(stall_cycles), .flush_count(flush_count)
    );

    typedef struct {
        string      name;
        logic [4:0] rs, rt;
        logic       urs, urt, br, tk, exmr, exrw;
        logic [4:0] exwr;
        logic       memmr;
        logic [4:0] memwr;
        logic       ms;
        logic       e_pcw, e_ifw, e_bub, e_fl, e_act;
    } vec_t;

    vec_t vt[16];

    // Expected counter value depends on whether the counters are built in.
    function automatic int cnt_exp(input int v);
`ifdef HAZARD_PERF_CNT_EN
        return v;
`else
        return 0 * v;
`endif
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input vec_t v);
        ID_Rs = v.rs; ID_Rt = v.rt; ID_usesRs = v.urs; ID_usesRt = v.urt;
        ID_isBranch = v.br; ID_branchTaken = v.tk;
        ID_Ex_MemRead = v.exmr; ID_Ex_Regwrite = v.exrw; ID_Ex_WriteReg = v.exwr;
        EX_MemMemRead = v.memmr; EX_MemWriteReg = v.memwr; mem_stall = v.ms;
    endtask

    task automatic clear();
        vec_t z;
        z = '{"z", 0,0,0,0,0,0,0,0,0,0,0,0, 1,1,0,0,0};
        drive(z);
    endtask

    task automatic do_reset();
        clear();
        reset = 1'b1;
        cycle();
        reset = 1'b0;
    endtask

    task automatic chk_outs(input string n, input logic pcw, input logic bub,
                            input logic fl, input logic act);
        #1;
        chk({n, ".pc_write"},     int'(pc_write),     int'(pcw));
        chk({n, ".IF_ID_write"},  int'(IF_ID_write),  int'(pcw));
        chk({n, ".bubble"},       int'(ID_Ex_bubble), int'(bub));
        chk({n, ".flush"},        int'(IF_ID_flush),  int'(fl));
        chk({n, ".stall_active"}, int'(stall_active), int'(act));
    endtask

    initial begin
        //          name         rs rt urs urt br tk exmr exrw exwr memmr memwr ms  pcw ifw bub fl act
        vt[0]  = '{"idle",        0, 0, 0, 0, 0, 0, 0, 0, 0,  0, 0, 0,  1,1,0,0,0};
        vt[1]  = '{"lu_rs",       5, 0, 1, 0, 0, 0, 1, 1, 5,  0, 0, 0,  0,0,1,0,1};
        vt[2]  = '{"lu_rt",       1, 9, 0, 1, 0, 0, 1, 1, 9,  0, 0, 0,  0,0,1,0,1};
        vt[3]  = '{"x0",          0, 0, 1, 0, 0, 0, 1, 1, 0,  0, 0, 0,  1,1,0,0,0};
        vt[4]  = '{"unused_rt",   1, 6, 0, 0, 0, 0, 1, 1, 6,  0, 0, 0,  1,1,0,0,0};
        vt[5]  = '{"br_alu",      7, 0, 1, 0, 1, 0, 0, 1, 7,  0, 0, 0,  0,0,1,0,1};
        vt[6]  = '{"br_memload",  2, 3, 0, 1, 1, 0, 0, 0, 0,  1, 3, 0,  0,0,1,0,1};
        vt[7]  = '{"alu_memload", 3, 0, 1, 0, 0, 0, 0, 0, 0,  1, 3, 0,  1,1,0,0,0};
        vt[8]  = '{"br_taken",    4, 8, 1, 1, 1, 1, 0, 0, 0,  0, 0, 0,  1,1,0,1,0};
        vt[9]  = '{"taken_stall", 7, 0, 1, 0, 1, 1, 0, 1, 7,  0, 0, 0,  0,0,1,0,1};
        vt[10] = '{"ms_taken",    4, 0, 1, 0, 1, 1, 0, 0, 0,  0, 0, 1,  0,0,0,0,0};
        vt[11] = '{"ms_loaduse",  5, 0, 1, 0, 0, 0, 1, 1, 5,  0, 0, 1,  0,0,0,0,1};
        vt[12] = '{"alu_fwd",     5, 0, 1, 0, 0, 0, 0, 1, 5,  0, 0, 0,  1,1,0,0,0};
        vt[13] = '{"lu_mismatch", 4, 0, 1, 0, 0, 0, 1, 1, 5,  0, 0, 0,  1,1,0,0,0};
        vt[14] = '{"br_nowrite",  7, 0, 1, 0, 1, 0, 0, 0, 7,  0, 0, 0,  1,1,0,0,0};
        vt[15] = '{"br_exload",   3, 0, 1, 0, 1, 0, 1, 1, 3,  0, 0, 0,  0,0,1,0,1};

        reset = 1'b1;
        clear();
        cycle();
        cycle();
        reset = 1'b0;
        chk_outs("reset", 1'b1, 1'b0, 1'b0, 1'b0);
        chk("reset.stall_cycles", int'(stall_cycles), 0);
        chk("reset.flush_count",  int'(flush_count),  0);

        for (int i = 0; i < 16; i++) begin
            do_reset();
            drive(vt[i]);
            #1;
            chk({vt[i].name, ".pc_write"},     int'(pc_write),     int'(vt[i].e_pcw));
            chk({vt[i].name, ".IF_ID_write"},  int'(IF_ID_write),  int'(vt[i].e_ifw));
            chk({vt[i].name, ".bubble"},       int'(ID_Ex_bubble), int'(vt[i].e_bub));
            chk({vt[i].name, ".flush"},        int'(IF_ID_flush),  int'(vt[i].e_fl));
            chk({vt[i].name, ".stall_active"}, int'(stall_active), int'(vt[i].e_act));
        end

        // Load-use: one bubble, then the load sits in MEM and no longer blocks.
        do_reset();
        drive(vt[1]);
        chk_outs("seq_lu.c0", 1'b0, 1'b1, 1'b0, 1'b1);
        cycle();
        clear();
        ID_Rs = 5; ID_usesRs = 1; EX_MemMemRead = 1; EX_MemWriteReg = 5;
        chk_outs("seq_lu.c1", 1'b1, 1'b0, 1'b0, 1'b0);
        chk("seq_lu.stall_cycles", int'(stall_cycles), cnt_exp(1));

        // Branch after load: two bubbles, taken ignored in STALL_LAST, then flush.
        do_reset();
        drive(vt[15]);
        chk_outs("seq_bl.c0", 1'b0, 1'b1, 1'b0, 1'b1);
        cycle();
        clear();
        ID_Rs = 3; ID_usesRs = 1; ID_isBranch = 1; ID_branchTaken = 1;
        EX_MemMemRead = 1; EX_MemWriteReg = 3;
        chk_outs("seq_bl.c1", 1'b0, 1'b1, 1'b0, 1'b1);
        cycle();
        EX_MemMemRead = 0; EX_MemWriteReg = 0;
        chk_outs("seq_bl.c2", 1'b1, 1'b0, 1'b1, 1'b0);
        cycle();
        ID_branchTaken = 0;
        chk("seq_bl.flush_count",  int'(flush_count),  cnt_exp(1));
        chk("seq_bl.stall_cycles", int'(stall_cycles), cnt_exp(2));

        // mem_stall freezes STALL_LAST for three cycles.
        do_reset();
        drive(vt[15]);
        cycle();
        clear();
        mem_stall = 1;
        for (int k = 0; k < 3; k++) begin
            chk_outs($sformatf("seq_ms.frz%0d", k), 1'b0, 1'b0, 1'b0, 1'b1);
            cycle();
        end
        mem_stall = 0;
        chk_outs("seq_ms.rel", 1'b0, 1'b1, 1'b0, 1'b1);
        cycle();
        chk_outs("seq_ms.idle", 1'b1, 1'b0, 1'b0, 1'b0);
        chk("seq_ms.stall_cycles", int'(stall_cycles), cnt_exp(2));

        // Reset while in STALL_LAST.
        do_reset();
        drive(vt[15]);
        cycle();
        clear();
        chk_outs("seq_rst.sl", 1'b0, 1'b1, 1'b0, 1'b1);
        reset = 1'b1;
        cycle();
        reset = 1'b0;
        chk_outs("seq_rst.after", 1'b1, 1'b0, 1'b0, 1'b0);
        chk("seq_rst.stall_cycles", int'(stall_cycles), 0);

        // Saturation with CNT_W=4: 20 load-use stall cycles.
        do_reset();
        drive(vt[1]);
        for (int k = 0; k < 14; k++) cycle();
        chk("sat.stall14", int'(stall_cycles), cnt_exp(14));
        for (int k = 0; k < 6; k++) cycle();
        chk("sat.stall20", int'(stall_cycles), cnt_exp(15));
        clear();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/hazard_stall_unit.md
Name: hazard_stall_unit

Overview:
- Producer-side complement to the forwarding unit: detects the RAW hazards that forwarding cannot cover, and stalls or flushes the front end.
- Covers load-use, and branch-in-ID compare operands still in flight.
- Sits beside the ID stage; drives PC/IF_ID write enables, ID_Ex bubble and IF_ID flush.
- Sequential multi-cycle stall FSM, plus optional performance counters.

Parameters:
- CNT_W, 32, width of the saturating performance counters.

Ports:
- clk  in  1  clock
- reset  in  1  reset
- ID_Rs  in  5  rs1 of instruction in ID
- ID_Rt  in  5  rs2 of instruction in ID
- ID_usesRs  in  1  ID instruction reads rs1
- ID_usesRt  in  1  ID instruction reads rs2
- ID_isBranch  in  1  ID instruction is a conditional branch (compare in ID)
- ID_branchTaken  in  1  branch/jump resolved taken in ID this cycle
- ID_Ex_MemRead  in  1  EX-stage instruction is a load
- ID_Ex_Regwrite  in  1  EX-stage instruction writes a register
- ID_Ex_WriteReg  in  5  EX-stage destination
- EX_MemMemRead  in  1  MEM-stage instruction is a load
- EX_MemWriteReg  in  5  MEM-stage destination
- mem_stall  in  1  data memory not ready; freeze whole pipeline
- pc_write  out  1  PC update enable
- IF_ID_write  out  1  IF/ID register enable
- ID_Ex_bubble  out  1  zero ID/EX control fields
- IF_ID_flush  out  1  squash instruction in IF/ID
- stall_active  out  1  FSM in a stall state
- stall_cycles  out  CNT_W  saturating count of hazard-stall cycles
- flush_count  out  CNT_W  saturating count of flushes

Behaviour:
- Clocking: single clock clk; reset is synchronous, active-high. On reset: state IDLE, counters 0.
- Match: a source matches a destination when its uses bit is 1, the destination is nonzero, and the register numbers are equal. x0 never hazards.
- need, computed combinationally in IDLE, highest value wins:
  - 2: ID_isBranch and a match on an EX load (ID_Ex_MemRead).
  - 1: load-use (ID_Ex_MemRead and a match, non-branch).
  - 1: ID_isBranch and a match on an EX ALU writer (ID_Ex_Regwrite, not MemRead).
  - 1: ID_isBranch and a match on a MEM load (EX_MemMemRead).
  - 0: otherwise.
- States: IDLE, STALL_LAST.
  - IDLE, need==0: pc_write=1, IF_ID_write=1, bubble=0.
  - IDLE, need==1: stall this cycle (pc_write=0, IF_ID_write=0, bubble=1). Stay IDLE; re-evaluate next cycle.
  - IDLE, need==2: stall this cycle; next state STALL_LAST.
  - STALL_LAST: stall unconditionally for one cycle, ignoring detection; then IDLE.
  - Total latency for branch-after-load: exactly 2 bubble cycles.
- Outputs are combinational from state and inputs. stall_active=1 iff state==STALL_LAST or need>0.
- Flush: IF_ID_flush = ID_branchTaken and not stalling and not mem_stall.
  - A taken resolution during a stall cycle is ignored; operands are stale and the branch re-resolves.
- mem_stall=1 overrides everything:
  - pc_write=0, IF_ID_write=0, bubble=0, flush=0.
  - FSM state holds; counters hold.
  - A pending STALL_LAST completes after mem_stall drops.
- Reset mid-stall: returns to IDLE next edge; no residual stall.
- Counters (feature enabled):
  - stall_cycles += 1 per hazard-stall cycle when mem_stall=0.
  - flush_count += 1 per IF_ID_flush.
  - Both saturate at all-ones and do not wrap.

Optional Feature:
- HAZARD_PERF_CNT_EN defined: stall_cycles and flush_count registers are implemented as above.
- Macro undefined: both outputs are tied to constant 0, no counter flops; hazard/stall/flush behaviour is identical.

Test Plan:
- Load-use: EX load writes x5, ID add reads x5 (usesRs=1) -> one cycle of pc_write=0, IF_ID_write=0, bubble=1; next cycle (load now in MEM, not branch) need=0; stall_cycles=1.
- Branch after ALU: EX add writes x7, ID beq reads x7 -> exactly 1 stall cycle; ID_branchTaken=1 during the stall -> IF_ID_flush=0.
- Branch after load: EX load writes x3, ID bne reads x3 -> stall 2 consecutive cycles (IDLE->STALL_LAST->IDLE); then taken -> IF_ID_flush=1, flush_count=1.
- x0 / unused operand: EX load writes x0 matching ID_Rs=0; separately ID_Rt matches with usesRt=0 -> no stall in either case.
- mem_stall: assert mem_stall while in STALL_LAST for 3 cycles -> all enables 0, bubble=0, state held; after release, 1 more stall cycle then IDLE; stall_cycles counts only the unfrozen stall cycles (2 total).
- Reset/saturation: reset asserted in STALL_LAST -> IDLE, counters 0 next edge; with CNT_W=4, 20 stall cycles -> stall_cycles=15.
